sram_arbiter: RTL and testbench

- Shares the single SRAM port between the VGA framebuffer fetcher and the CPU data bus.
- VGA reads have priority; a starvation counter bounds how long the CPU can be held off.
- Sits between VGA_out/CPU memory stage and the SRAM: forwards address, byte select and write data; returns read data and a per-requester ack.
- One transfer is in flight at a time; a granted transfer is never pre-empted.

---
 rtl/sram_arb_pkg.sv | 24 ++
 rtl/sram_arb_starve_cnt.sv | 43 ++++
 rtl/sram_arbiter.sv | 164 ++++++++++++++++
 tb/tb_sram_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the SRAM arbiter slice.
//   arb_state_t : arbiter FSM states
//   grant_t     : encoding of the grant output (current SRAM owner)
//   VGA_SEL     : byte select driven for every VGA fetch (full word)
package sram_arb_pkg;

  localparam int unsigned SEL_W = 4;
  localparam int unsigned CNT_W = 4;

  localparam logic [SEL_W-1:0] VGA_SEL = 4'hF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    VGA_ACC = 2'd1,
    CPU_ACC = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_VGA  = 2'd1,
    GNT_CPU  = 2'd2
  } grant_t;

endpackage

// File: rtl/sram_arb_starve_cnt.sv
// Saturating count of VGA grants handed out while the CPU was waiting.
// Ports:
//   clk, rst : clock, async active-high reset
//   inc      : count one more VGA grant (ignored once at MAX)
//   clr      : clear the count (CPU granted); wins over inc
//   at_max   : registered flag, count == MAX
module sram_arb_starve_cnt
  import sram_arb_pkg::*;
#(
  parameter int unsigned MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;

  // Next count: clear dominates, increment saturates at MAX.
  always_comb begin
    count_nxt = count;
    if (clr) begin
      count_nxt = '0;
    end else if (inc && !at_max) begin
      count_nxt = count + CNT_W'(1);
    end
  end

  // at_max is registered from the next count so it tracks count exactly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count  <= '0;
      at_max <= 1'b0;
    end else begin
      count  <= count_nxt;
      at_max <= (count_nxt == CNT_W'(MAX));
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one SRAM port between the VGA framebuffer fetcher and the CPU
// data bus. VGA has priority; a starvation counter forces the CPU through
// after CPU_MAX_WAIT VGA grants. One transfer in flight, never pre-empted.
// Ports:
//   clk, rst                         : clock, async active-high reset
//   vga_req/addr -> vga_ack/rdata    : VGA read channel
//   cpu_read/write/addr/wdata/sel    : CPU request channel
//   cpu_ack/rdata                    : CPU completion / read data
//   sram_read/write/addr/wdata/sel   : SRAM command (registered)
//   sram_rdata, sram_busy            : SRAM response / wait
//   grant                            : current owner (0 none, 1 VGA, 2 CPU)
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned CPU_MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic              vga_ack,
  output logic [DATA_W-1:0] vga_rdata,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic [3:0]        cpu_sel,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              sram_read,
  output logic              sram_write,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  output logic [3:0]        sram_sel,
  input  logic [DATA_W-1:0] sram_rdata,
  input  logic              sram_busy,
  output logic [1:0]        grant
);

  arb_state_t        state, state_nxt;
  grant_t            grant_q, grant_nxt;
  logic              vga_ack_nxt, cpu_ack_nxt;
  logic              sram_read_nxt, sram_write_nxt;
  logic [ADDR_W-1:0] sram_addr_nxt;
  logic [DATA_W-1:0] sram_wdata_nxt, vga_rdata_nxt, cpu_rdata_nxt;
  logic [3:0]        sram_sel_nxt;
  logic              vga_elig, cpu_elig;
  logic              starve_inc, starve_clr, starve_at_max;

  // A requester is blocked during its own ack cycle (request not yet dropped).
  assign vga_elig = vga_req & ~vga_ack;
  assign cpu_elig = (cpu_read | cpu_write) & ~cpu_ack;
  assign grant    = grant_q;

  sram_arb_starve_cnt #(
    .MAX (CPU_MAX_WAIT)
  ) u_starve (
    .clk    (clk),
    .rst    (rst),
    .inc    (starve_inc),
    .clr    (starve_clr),
    .at_max (starve_at_max)
  );

  // Next-state and next-output logic; all outputs are registered below.
  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant_q;
    vga_ack_nxt    = 1'b0;
    cpu_ack_nxt    = 1'b0;
    vga_rdata_nxt  = vga_rdata;
    cpu_rdata_nxt  = cpu_rdata;
    sram_read_nxt  = sram_read;
    sram_write_nxt = sram_write;
    sram_addr_nxt  = sram_addr;
    sram_wdata_nxt = sram_wdata;
    sram_sel_nxt   = sram_sel;
    starve_inc     = 1'b0;
    starve_clr     = 1'b0;

    case (state)
      IDLE: begin
        if (cpu_elig && (starve_at_max || !vga_elig)) begin
          // Read+write together is a write; reads drive zero write data.
          state_nxt      = CPU_ACC;
          grant_nxt      = GNT_CPU;
          sram_write_nxt = cpu_write;
          sram_read_nxt  = ~cpu_write;
          sram_addr_nxt  = cpu_addr;
          sram_wdata_nxt = cpu_write ? cpu_wdata : '0;
          sram_sel_nxt   = cpu_write ? cpu_sel : VGA_SEL;
          starve_clr     = 1'b1;
        end else if (vga_elig) begin
          state_nxt      = VGA_ACC;
          grant_nxt      = GNT_VGA;
          sram_read_nxt  = 1'b1;
          sram_write_nxt = 1'b0;
          sram_addr_nxt  = vga_addr;
          sram_wdata_nxt = '0;
          sram_sel_nxt   = VGA_SEL;
          starve_inc     = cpu_elig;
        end
      end

      VGA_ACC, CPU_ACC: begin
        // Command held until the SRAM drops busy; that edge completes it.
        if (!sram_busy) begin
          if (state == VGA_ACC) begin
            vga_ack_nxt   = 1'b1;
            vga_rdata_nxt = sram_rdata;
          end else begin
            cpu_ack_nxt = 1'b1;
            if (sram_read) begin
              cpu_rdata_nxt = sram_rdata;
            end
          end
          sram_read_nxt  = 1'b0;
          sram_write_nxt = 1'b0;
          grant_nxt      = GNT_NONE;
          state_nxt      = IDLE;
        end
      end

      default: begin
        state_nxt      = IDLE;
        grant_nxt      = GNT_NONE;
        sram_read_nxt  = 1'b0;
        sram_write_nxt = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      grant_q    <= GNT_NONE;
      vga_ack    <= 1'b0;
      cpu_ack    <= 1'b0;
      vga_rdata  <= '0;
      cpu_rdata  <= '0;
      sram_read  <= 1'b0;
      sram_write <= 1'b0;
      sram_addr  <= '0;
      sram_wdata <= '0;
      sram_sel   <= '0;
    end else begin
      state      <= state_nxt;
      grant_q    <= grant_nxt;
      vga_ack    <= vga_ack_nxt;
      cpu_ack    <= cpu_ack_nxt;
      vga_rdata  <= vga_rdata_nxt;
      cpu_rdata  <= cpu_rdata_nxt;
      sram_read  <= sram_read_nxt;
      sram_write <= sram_write_nxt;
      sram_addr  <= sram_addr_nxt;
      sram_wdata <= sram_wdata_nxt;
      sram_sel   <= sram_sel_nxt;
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: directed scenarios plus random
// traffic, a behavioural arbitration model feeding an expected-transfer
// queue, and a negedge monitor comparing the DUT against it.
module tb_sram_arbiter;

  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned MAX_WAIT = 4;

  logic        tb_clk = 1'b0;
  logic        rst = 1'b1;
  logic        vga_req = 1'b0;
  logic [31:0] vga_addr = '0;
  logic        cpu_read = 1'b0;
  logic        cpu_write = 1'b0;
  logic [31:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic [3:0]  cpu_sel = '0;
  logic        sram_busy = 1'b0;
  logic [31:0] sram_rdata;
  logic        vga_ack, cpu_ack, sram_read, sram_write;
  logic [31:0] vga_rdata, cpu_rdata, sram_addr, sram_wdata;
  logic [3:0]  sram_sel;
  logic [1:0]  grant;

  always #5 tb_clk = ~tb_clk;

  sram_arbiter #(
    .ADDR_W       (ADDR_W),
    .DATA_W       (DATA_W),
    .CPU_MAX_WAIT (MAX_WAIT)
  ) dut (
    .clk        (tb_clk),
    .rst        (rst),
    .vga_req    (vga_req),
    .vga_addr   (vga_addr),
    .vga_ack    (vga_ack),
    .vga_rdata  (vga_rdata),
    .cpu_read   (cpu_read),
    .cpu_write  (cpu_write),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_sel    (cpu_sel),
    .cpu_ack    (cpu_ack),
    .cpu_rdata  (cpu_rdata),
    .sram_read  (sram_read),
    .sram_write (sram_write),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_sel   (sram_sel),
    .sram_rdata (sram_rdata),
    .sram_busy  (sram_busy),
    .grant      (grant)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] sel);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // SRAM device: written by DUT commands, reads served from this array.
  logic [31:0] mem [64];
  assign sram_rdata = sram_read ? mem[sram_addr[5:0]] : 32'h0;
  always @(posedge tb_clk)
    if (!rst && sram_write && !sram_busy)
      mem[sram_addr[5:0]] <= merge(mem[sram_addr[5:0]], sram_wdata, sram_sel);

  // Reference model: who owns the SRAM, the starvation tally, and the acks.
  typedef struct {
    logic [1:0]  who;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sel;
    logic [31:0] rdata;
  } txn_t;

  txn_t        exp_q[$];
  txn_t        m_t;
  logic [31:0] ref_mem [64];
  logic [1:0]  m_owner = 2'd0;
  int          m_cnt = 0;
  logic        m_vack = 1'b0, m_cack = 1'b0;
  logic        v_el, c_el;

  always @(posedge tb_clk or posedge rst) begin
    if (rst) begin
      m_owner = 2'd0; m_cnt = 0; m_vack = 1'b0; m_cack = 1'b0;
      exp_q.delete();
    end else if (m_owner != 2'd0) begin
      m_vack = 1'b0; m_cack = 1'b0;
      if (!sram_busy) begin
        if (m_owner == 2'd1) m_vack = 1'b1; else m_cack = 1'b1;
        m_owner = 2'd0;
      end
    end else begin
      v_el = vga_req && !m_vack;
      c_el = (cpu_read || cpu_write) && !m_cack;
      m_vack = 1'b0; m_cack = 1'b0;
      if (c_el && (m_cnt == int'(MAX_WAIT) || !v_el)) begin
        m_owner = 2'd2; m_cnt = 0;
        m_t.who = 2'd2; m_t.wr = cpu_write; m_t.addr = cpu_addr;
        m_t.wdata = cpu_write ? cpu_wdata : 32'h0; m_t.sel = cpu_sel;
        m_t.rdata = ref_mem[cpu_addr[5:0]];
        if (cpu_write) ref_mem[cpu_addr[5:0]] = merge(ref_mem[cpu_addr[5:0]], cpu_wdata, cpu_sel);
        exp_q.push_back(m_t);
      end else if (v_el) begin
        m_owner = 2'd1;
        if (c_el && m_cnt < int'(MAX_WAIT)) m_cnt++;
        m_t.who = 2'd1; m_t.wr = 1'b0; m_t.addr = vga_addr; m_t.wdata = 32'h0;
        m_t.sel = 4'hF; m_t.rdata = ref_mem[vga_addr[5:0]];
        exp_q.push_back(m_t);
      end
    end
  end

  // Monitor: compares grant/acks every cycle, the command while granted,
  // and pops the expected transfer whenever the DUT acks.
  bit          mon_en = 1'b0;
  logic [31:0] exp_vrd = '0, exp_crd = '0;
  txn_t        mon_t;

  always @(negedge tb_clk) begin
    if (rst) begin exp_vrd = '0; exp_crd = '0; end
    if (mon_en) begin
      chk("grant", 32'(grant), 32'(m_owner));
      chk("vga_ack", 32'(vga_ack), 32'(m_vack));
      chk("cpu_ack", 32'(cpu_ack), 32'(m_cack));
      if (grant != 2'd0) begin
        if (exp_q.size() == 0) fail_now("command_without_expected_txn");
        else begin
          chk("sram_addr", sram_addr, exp_q[0].addr);
          chk("sram_write", 32'(sram_write), 32'(exp_q[0].wr));
          chk("sram_read", 32'(sram_read), 32'(!exp_q[0].wr));
          chk("sram_wdata", sram_wdata, exp_q[0].wdata);
          if (exp_q[0].wr || exp_q[0].who == 2'd1) chk("sram_sel", 32'(sram_sel), 32'(exp_q[0].sel));
        end
      end
      if (vga_ack || cpu_ack) begin
        if (exp_q.size() == 0) fail_now("ack_without_expected_txn");
        else begin
          mon_t = exp_q.pop_front();
          chk("ack_owner", vga_ack ? 32'd1 : 32'd2, 32'(mon_t.who));
          if (vga_ack) begin
            exp_vrd = mon_t.rdata;
            chk("vga_rdata", vga_rdata, exp_vrd);
          end else if (!mon_t.wr) begin
            exp_crd = mon_t.rdata;
            chk("cpu_rdata", cpu_rdata, exp_crd);
          end else begin
            chk("cpu_rdata_hold", cpu_rdata, exp_crd);
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  logic [31:0] old20;
  int          vacks, vb, op;
  bit          got;

  initial begin
    for (int i = 0; i < 64; i++) begin mem[i] = $urandom; ref_mem[i] = mem[i]; end
    mem[16] = 32'h02468ACF; ref_mem[16] = 32'h02468ACF;
    old20 = mem[32];

    // Reset state
    repeat (3) @(negedge tb_clk);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_vga_ack", 32'(vga_ack), 32'd0);
    chk("rst_cpu_ack", 32'(cpu_ack), 32'd0);
    chk("rst_sram_read", 32'(sram_read), 32'd0);
    chk("rst_sram_write", 32'(sram_write), 32'd0);
    chk("rst_sram_addr", sram_addr, 32'd0);
    rst = 1'b0; mon_en = 1'b1;
    @(negedge tb_clk);

    // Zero-wait VGA read
    vga_req = 1'b1; vga_addr = 32'h10; sram_busy = 1'b0;
    @(negedge tb_clk);
    chk("vga_cmd_read", 32'(sram_read), 32'd1);
    chk("vga_cmd_grant", 32'(grant), 32'd1);
    chk("vga_cmd_addr", sram_addr, 32'h10);
    chk("vga_cmd_sel", 32'(sram_sel), 32'hF);
    chk("vga_early_ack", 32'(vga_ack), 32'd0);
    @(negedge tb_clk);
    chk("vga_ack_edge2", 32'(vga_ack), 32'd1);
    chk("vga_rdata_val", vga_rdata, 32'h02468ACF);
    chk("vga_grant_done", 32'(grant), 32'd0);
    chk("vga_read_done", 32'(sram_read), 32'd0);
    vga_req = 1'b0;
    @(negedge tb_clk);
    chk("vga_ack_pulse", 32'(vga_ack), 32'd0);

    // CPU write with three busy cycles
    cpu_write = 1'b1; cpu_addr = 32'h20; cpu_wdata = 32'hDEADBEEF; cpu_sel = 4'b0011;
    sram_busy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge tb_clk);
      chk("cw_write", 32'(sram_write), 32'd1);
      chk("cw_wdata", sram_wdata, 32'hDEADBEEF);
      chk("cw_sel", 32'(sram_sel), 32'h3);
      chk("cw_no_ack", 32'(cpu_ack), 32'd0);
      if (k == 3) sram_busy = 1'b0;
    end
    @(negedge tb_clk);
    chk("cw_ack", 32'(cpu_ack), 32'd1);
    chk("cw_write_done", 32'(sram_write), 32'd0);
    cpu_write = 1'b0;
    @(negedge tb_clk);

    // Simultaneous VGA and CPU read: VGA first, CPU in VGA's ack cycle
    vga_req = 1'b1; vga_addr = 32'h05; cpu_read = 1'b1; cpu_addr = 32'h20;
    @(negedge tb_clk);
    chk("sim_first_vga", 32'(grant), 32'd1);
    @(negedge tb_clk);
    chk("sim_vga_ack", 32'(vga_ack), 32'd1);
    @(negedge tb_clk);
    chk("sim_then_cpu", 32'(grant), 32'd2);
    @(negedge tb_clk);
    chk("sim_cpu_ack", 32'(cpu_ack), 32'd1);
    chk("sim_cpu_rdata_merged", cpu_rdata, {old20[31:16], 16'hBEEF});
    cpu_read = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge tb_clk);
      if (vga_ack) begin got = 1'b1; vga_req = 1'b0; end
    end
    chk("sim_vga_second", 32'(got), 32'd1);
    @(negedge tb_clk);

    // Read and write together is a write
    cpu_read = 1'b1; cpu_write = 1'b1; cpu_addr = 32'h07; cpu_wdata = $urandom; cpu_sel = 4'hF;
    @(negedge tb_clk);
    chk("rw_write", 32'(sram_write), 32'd1);
    chk("rw_read", 32'(sram_read), 32'd0);
    @(negedge tb_clk);
    chk("rw_ack", 32'(cpu_ack), 32'd1);
    cpu_read = 1'b0; cpu_write = 1'b0;
    @(negedge tb_clk);

    // Starvation bound: CPU re-requests only outside VGA ack cycles
    vga_req = 1'b1; vga_addr = 32'($urandom_range(0, 63));
    cpu_read = 1'b1; cpu_addr = 32'($urandom_range(0, 63));
    vacks = 0; vb = -1; got = 1'b0;
    for (int c = 0; c < 100 && !got; c++) begin
      @(negedge tb_clk);
      if (cpu_ack) begin got = 1'b1; vb = vacks; cpu_read = 1'b0; end
      else begin
        if (vga_ack) begin vacks++; vga_addr = 32'($urandom_range(0, 63)); end
        cpu_read = !vga_ack;
      end
    end
    chk("starve_cpu_served", 32'(got), 32'd1);
    chk("starve_vga_acks", 32'(vb), 32'(MAX_WAIT));
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge tb_clk);
      if (cpu_ack) fail_now("starve_extra_cpu_ack");
      if (vga_ack) begin got = 1'b1; vga_req = 1'b0; end
    end
    chk("starve_vga_resumes", 32'(got), 32'd1);
    @(negedge tb_clk);

    // Random traffic with random SRAM wait states
    for (int c = 0; c < 3000; c++) begin
      @(negedge tb_clk);
      if (!vga_req || vga_ack) begin
        vga_req  = ($urandom_range(0, 2) != 0);
        vga_addr = 32'($urandom_range(0, 63));
      end
      if (!(cpu_read || cpu_write) || cpu_ack) begin
        op        = int'($urandom_range(0, 3));
        cpu_read  = (op == 1) || (op == 3);
        cpu_write = (op == 2) || (op == 3);
        cpu_addr  = 32'($urandom_range(0, 63));
        cpu_wdata = $urandom;
        cpu_sel   = 4'($urandom_range(0, 15));
      end
      sram_busy = ($urandom_range(0, 3) == 0);
    end
    for (int c = 0; c < 200 && (vga_req || cpu_read || cpu_write); c++) begin
      @(negedge tb_clk);
      if (vga_ack) vga_req = 1'b0;
      if (cpu_ack) begin cpu_read = 1'b0; cpu_write = 1'b0; end
      sram_busy = 1'b0;
    end
    if (vga_req || cpu_read || cpu_write) fail_now("drain_timeout");
    repeat (3) @(negedge tb_clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of a stalled VGA access
    vga_req = 1'b1; vga_addr = 32'h03; sram_busy = 1'b1;
    @(negedge tb_clk);
    chk("rstmid_granted", 32'(grant), 32'd1);
    @(posedge tb_clk);
    #1 rst = 1'b1;
    #1;
    chk("rstmid_grant", 32'(grant), 32'd0);
    chk("rstmid_read", 32'(sram_read), 32'd0);
    chk("rstmid_vga_ack", 32'(vga_ack), 32'd0);
    chk("rstmid_cpu_ack", 32'(cpu_ack), 32'd0);
    @(negedge tb_clk);
    vga_req = 1'b0; sram_busy = 1'b0;
    @(negedge tb_clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge tb_clk);
      chk("rstmid_no_ack", 32'(vga_ack), 32'd0);
      chk("rstmid_idle", 32'(grant), 32'd0);
    end

    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
